sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, first-word-fall-through-free synchronous FIFO with registered read data, full/empty and programmable almost-full/almost-empty flags. Used wherever a producer and consumer share one clock but have bursty, independent rates. Storage is an inferred RAM of 2**ADDR_WIDTH words; the RAM style is selectable on Xilinx platforms.

Parameters:
DATA_WIDTH, 8, width of one FIFO word in bits.
ADDR_WIDTH, 8, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 256 words).
RAM_TYPE, "distributed", Xilinx-only ram_style hint: "distributed" or "block"; present only when XILINX_PLATFORM is defined.
ALMOST_FULL_VAL, 2, almost_full asserts when free slots <= this value.
ALMOST_EMPTY_VAL, 2, almost_empty asserts when stored words <= this value.

Ports:
i_clk  in  1  system clock; all logic is on the rising edge.
i_s_rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to i_clk.
i_wr_en  in  1  write request; data is accepted on the rising edge when i_wr_en=1 and o_full=0.
i_wr_data  in  DATA_WIDTH  write data.
o_almost_full  out  1  occupancy >= DEPTH-ALMOST_FULL_VAL.
o_full  out  1  occupancy == DEPTH.
i_rd_en  in  1  read request; accepted on the rising edge when i_rd_en=1 and o_empty=0.
o_rd_data  out  DATA_WIDTH  read data, registered.
o_almost_empty  out  1  occupancy <= ALMOST_EMPTY_VAL.
o_empty  out  1  occupancy == 0.
o_rd_valid  out  1  one-cycle pulse qualifying o_rd_data.

Behaviour:
- Reset (i_s_rst_n=0, async): wr/rd pointers=0, count=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_rd_valid=0, o_rd_data=0. RAM contents are not reset.
- Pointers are ADDR_WIDTH+1 bits; the MSB distinguishes full from empty, and the low ADDR_WIDTH bits address the RAM. They wrap naturally modulo 2*DEPTH.
- Occupancy count is a register of ADDR_WIDTH+1 bits. Each edge: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither.
- Flags are decoded from registered count/pointers. They reflect the state after the edge; no combinational path exists from i_wr_en/i_rd_en.
- Write when full: ignored. No pointer or count change; data is dropped.
- Read when empty: ignored. o_rd_valid stays 0.
- Read latency: an accepted read at edge N makes o_rd_data=mem[rd_ptr] and o_rd_valid=1 after edge N. o_rd_valid returns to 0 after edge N+1 unless another read is accepted. o_rd_data holds its last value when idle.
- Simultaneous write+read, non-empty and non-full: both are performed and count is unchanged.
- Simultaneous write+read when empty: only the write is performed. When full: only the read is performed.
- Write-then-read of the same address in the same cycle cannot happen, because a read requires non-empty.
- Ordering: strict FIFO. Words are read in exactly the order written, across any number of pointer wraps.
- Reset asserted mid-operation discards all contents immediately; flags return to reset values.

Decomposition:
- Shared package fifo_pkg: DEPTH function/constant (2**ADDR_WIDTH), RAM_TYPE string constants, and a count-to-flag helper function.
- Sub-module sync_fifo_ram: simple dual-port RAM (one write port, one registered read port) carrying the RAM_TYPE ram_style attribute.
- Companion stimulus block random_state_generator (own spec):
  - Parameters STATE_0_MIN_VAL/MAX_VAL and STATE_1_MIN_VAL/MAX_VAL.
  - Ports i_clk, i_s_rst_n, o_state.
  - o_state=0 after reset, then toggles. Each dwell length is drawn uniformly from the current state's [MIN,MAX] cycle range by an internal LFSR.

Test Plan:
- Reset check: hold i_s_rst_n=0 -> o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_rd_valid=0, o_rd_data=0.
- Fill: 256 writes of 0..255 with no reads -> o_almost_full rises after the 254th write, o_full after the 256th. A 257th write is ignored.
- Drain: 256 reads after fill -> o_rd_valid pulses one cycle after each accepted read with data 0..255 in order. o_almost_empty=1 once count<=2; o_empty=1 after the last read. An extra read gives no o_rd_valid.
- Simultaneous: at count=10, assert both enables for 20 cycles -> count stays 10, flags unchanged, data order preserved.
- Random: gate i_wr_en/i_rd_en with four random_state_generator instances (slow 100-350/80-500, fast 50-100/20-80) and with !full/!empty, writing an incrementing byte. Run 1,000,000 cycles -> each o_rd_valid data equals a running 8-bit counter; zero errors.
- Reset mid-stream: assert reset with count=100 -> all outputs return to reset values immediately. A subsequent write of 0xA5 reads back as 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Flag decode lives here so the top and any future variants agree on thresholds.
package fifo_pkg;

  localparam string RAM_DISTRIBUTED = "distributed";
  localparam string RAM_BLOCK       = "block";

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
  } fifo_flags_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic fifo_flags_t count_to_flags(input int unsigned count,
                                                 input int unsigned depth,
                                                 input int unsigned af_val,
                                                 input int unsigned ae_val);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.almost_empty = (count <= ae_val);
    f.full         = (count == depth);
    f.almost_full  = (count + af_val >= depth);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// The output register resets to zero; the array itself is never reset.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
`ifdef XILINX_PLATFORM
  ,
  parameter string RAM_TYPE = RAM_DISTRIBUTED
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

`ifdef XILINX_PLATFORM
  (* ram_style = RAM_TYPE *)
`endif
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Holds its last value when no read is requested.
  always_ff @(posedge i_clk or negedge i_s_rst_n) begin
    if (!i_s_rst_n)   rd_data_q <= '0;
    else if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered-state flags.
// Flags depend only on the occupancy register, never on this cycle's enables.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
`ifdef XILINX_PLATFORM
  parameter string RAM_TYPE = RAM_DISTRIBUTED,
`endif
  parameter int ALMOST_FULL_VAL  = 2,
  parameter int ALMOST_EMPTY_VAL = 2
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_almost_full,
  output logic                  o_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_almost_empty,
  output logic                  o_empty,
  output logic                  o_rd_valid
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q,  count_d;
  logic                rd_valid_q;
  fifo_flags_t         flags;
  logic                wr_ok;
  logic                rd_ok;

  assign flags = count_to_flags(32'(count_q), DEPTH,
                                ALMOST_FULL_VAL, ALMOST_EMPTY_VAL);

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign wr_ok = i_wr_en & ~flags.full;
  assign rd_ok = i_rd_en & ~flags.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_s_rst_n) begin
    if (!i_s_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
`ifdef XILINX_PLATFORM
    ,
    .RAM_TYPE   (RAM_TYPE)
`endif
  ) u_ram (
    .i_clk     (i_clk),
    .i_s_rst_n (i_s_rst_n),
    .i_wr_en   (wr_ok),
    .i_wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (rd_ok),
    .i_rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .o_rd_data (o_rd_data)
  );

  assign o_empty        = flags.empty;
  assign o_almost_empty = flags.almost_empty;
  assign o_full         = flags.full;
  assign o_almost_full  = flags.almost_full;
  assign o_rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
// Every cycle all outputs are compared with what the model says they must be.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AFV   = 2;
  localparam int AEV   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          almost_full, full, almost_empty, empty, rd_valid;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW),
    .ALMOST_FULL_VAL  (AFV),
    .ALMOST_EMPTY_VAL (AEV)
  ) dut (
    .i_clk          (clk),
    .i_s_rst_n      (rst_n),
    .i_wr_en        (wr_en),
    .i_wr_data      (wr_data),
    .o_almost_full  (almost_full),
    .o_full         (full),
    .i_rd_en        (rd_en),
    .o_rd_data      (rd_data),
    .o_almost_empty (almost_empty),
    .o_empty        (empty),
    .o_rd_valid     (rd_valid)
  );

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid;
  int            n_cmp;
  int            n_err;
  logic [DW-1:0] wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".empty"},        32'(empty),        32'(sz == 0));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEV));
    check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= DEPTH - AFV));
    check({tag, ".rd_valid"},     32'(rd_valid),     32'(exp_rd_valid));
    check({tag, ".rd_data"},      32'(rd_data),      32'(exp_rd_data));
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rd_data  = '0;
    exp_rd_valid = 1'b0;
  endtask

  // One clock: drive, let the edge happen, update model from pre-edge occupancy, check.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
    bit wacc, racc;
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    @(posedge clk);
    wacc = wr && (model_q.size() < DEPTH);
    racc = rd && (model_q.size() > 0);
    if (racc) exp_rd_data = model_q.pop_front();
    exp_rd_valid = racc;
    if (wacc) model_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int dwell, wr_pct, rd_pct;
    n_cmp = 0;
    n_err = 0;
    wd    = '0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Fill past capacity; the last write must be dropped.
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), "fill");

    // Drain past empty; the last read must produce no valid.
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, '0, "drain");
    step(1'b0, 1'b0, '0, "idle_hold");

    // Simultaneous read/write at a steady occupancy of 10.
    for (int i = 0; i < 10; i++) begin step(1'b1, 1'b0, wd, "simul_pre"); wd++; end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, wd, "simul");
      wd++;
      check("simul.count", 32'(model_q.size()), 32'd10);
    end
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, '0, "simul_drain");
    // Simultaneous request while empty: only the write happens.
    step(1'b1, 1'b1, 8'h3C, "simul_empty");
    step(1'b0, 1'b1, '0, "simul_empty_rd");

    // Random bursts with varying write/read densities.
    dwell = 0; wr_pct = 50; rd_pct = 50;
    for (int c = 0; c < 20000; c++) begin
      if (dwell == 0) begin
        dwell  = $urandom_range(400, 20);
        wr_pct = $urandom_range(100, 0);
        rd_pct = $urandom_range(100, 0);
      end
      dwell--;
      step($urandom_range(99, 0) < wr_pct, $urandom_range(99, 0) < rd_pct, wd, "random");
      wd++;
    end

    // Reset mid-stream at occupancy 100.
    while (model_q.size() > 0) step(1'b0, 1'b1, '0, "pre_rst_drain");
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'(i + 7), "pre_rst_fill");
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    check_all("mid_rst_hold");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5, "post_rst_wr");
    step(1'b0, 1'b1, '0, "post_rst_rd");
    step(1'b0, 1'b0, '0, "post_rst_data");
    check("post_rst.a5", 32'(rd_data), 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
